// File: rtl/matrix_bram_reader_pkg.sv
// matrix_pkg: shared types and constants for the matrix store readers.
// Element type, reader FSM states and the output FIFO depth.
package matrix_pkg;

    localparam int ELEM_WIDTH = 32;
    localparam int READER_FIFO_DEPTH = 4;

    typedef logic [ELEM_WIDTH-1:0] matrix_elem_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rd_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_bram_reader_if.sv
// matrix_bram_reader_if: control, BRAM read port and output stream.
// master = reader side, slave = environment (BRAM + consumer).
interface matrix_bram_reader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int ROW_WIDTH  = 3,
    parameter int COL_WIDTH  = 3
);
    logic                  start;
    logic                  transpose;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_dout;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ROW_WIDTH-1:0]  out_row;
    logic [COL_WIDTH-1:0]  out_col;
    logic                  out_last;

    modport master (
        input  start, transpose, bram_dout, out_ready,
        output busy, done, bram_addr,
        output out_valid, out_data, out_row, out_col, out_last
    );

    modport slave (
        output start, transpose, bram_dout, out_ready,
        input  busy, done, bram_addr,
        input  out_valid, out_data, out_row, out_col, out_last
    );
endinterface

// File: rtl/matrix_stream_fifo.sv
// matrix_stream_fifo: small synchronous FIFO with occupancy count.
// Head is read combinationally; storage is not cleared on reset.
module matrix_stream_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] P_MAX = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;

    // storage write, data only
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == P_MAX) ? '0 : wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == P_MAX) ? '0 : rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/matrix_bram_reader.sv
// matrix_bram_reader: walks a ROWSxCOLS BRAM in row- or column-major
// order and streams elements tagged with row/col/last.
module matrix_bram_reader
    import matrix_pkg::*;
#(
    parameter int ROWS       = 5,
    parameter int COLS       = 5,
    parameter int ADDR_WIDTH = clog2_min1(ROWS * COLS),
    parameter int DATA_WIDTH = 32
) (
    input logic clk,
    input logic rst_n,
    matrix_bram_reader_if.master bus
);
    localparam int ROW_W = clog2_min1(ROWS);
    localparam int COL_W = clog2_min1(COLS);
    localparam int ENT_W = 1 + ROW_W + COL_W + DATA_WIDTH;
    localparam int CNT_W = $clog2(READER_FIFO_DEPTH + 1);
    localparam logic [ROW_W-1:0] R_MAX = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] C_MAX = COL_W'(COLS - 1);

    rd_state_t state, state_nxt;

    logic [ROW_W-1:0]      r_q;
    logic [COL_W-1:0]      c_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  walk_tr;

    logic                  tag_v;
    logic [ROW_W-1:0]      tag_r;
    logic [COL_W-1:0]      tag_c;
    logic                  tag_last;
    logic                  done_q;

    logic [ENT_W-1:0]      fifo_din;
    logic [ENT_W-1:0]      fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_cnt;

    logic                  start_ok;
    logic                  is_last;
    logic                  pop;
    logic                  credit_ok;
    logic                  issue;
    logic                  last_pop;

    assign start_ok  = (state == IDLE) && bus.start;
    assign is_last   = (r_q == R_MAX) && (c_q == C_MAX);
    assign pop       = !fifo_empty && bus.out_ready;
    assign credit_ok = !fifo_full &&
                       (int'(fifo_cnt) + int'(tag_v) <
                        READER_FIFO_DEPTH + int'(pop));
    assign issue     = (state == RUN) && credit_ok;
    assign last_pop  = pop && fifo_dout[ENT_W-1];
    assign fifo_din  = {tag_last, tag_r, tag_c, bus.bram_dout};

    matrix_stream_fifo #(
        .DEPTH (READER_FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tag_v),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (issue && is_last) state_nxt = DRAIN;
            DRAIN:   if (last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs and stream head, zeroed while the FIFO is empty
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.done      = done_q;
        bus.bram_addr = addr_q;
        bus.out_valid = !fifo_empty;
        bus.out_last  = 1'b0;
        bus.out_row   = '0;
        bus.out_col   = '0;
        bus.out_data  = '0;
        if (!fifo_empty) begin
            bus.out_last = fifo_dout[ENT_W-1];
            bus.out_row  = fifo_dout[ENT_W-2 -: ROW_W];
            bus.out_col  = fifo_dout[DATA_WIDTH+COL_W-1 -: COL_W];
            bus.out_data = fifo_dout[DATA_WIDTH-1:0];
        end
    end

    // walk counters: addr_q is the address presented to the BRAM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q     <= '0;
            c_q     <= '0;
            addr_q  <= '0;
            walk_tr <= 1'b0;
        end else if (start_ok) begin
            r_q     <= '0;
            c_q     <= '0;
            addr_q  <= '0;
            walk_tr <= bus.transpose;
        end else if (issue) begin
            if (is_last) begin
                r_q    <= '0;
                c_q    <= '0;
                addr_q <= '0;
            end else if (!walk_tr) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                if (c_q == C_MAX) begin
                    c_q <= '0;
                    r_q <= r_q + ROW_W'(1);
                end else begin
                    c_q <= c_q + COL_W'(1);
                end
            end else if (r_q == R_MAX) begin
                r_q    <= '0;
                c_q    <= c_q + COL_W'(1);
                addr_q <= ADDR_WIDTH'(c_q) + ADDR_WIDTH'(1);
            end else begin
                r_q    <= r_q + ROW_W'(1);
                addr_q <= addr_q + ADDR_WIDTH'(COLS);
            end
        end
    end

    // tag pipe aligned with the BRAM read latency, plus done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v    <= 1'b0;
            tag_r    <= '0;
            tag_c    <= '0;
            tag_last <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tag_v    <= issue;
            tag_r    <= r_q;
            tag_c    <= c_q;
            tag_last <= is_last;
            done_q   <= (state == DRAIN) && last_pop;
        end
    end
endmodule

// File: tb/tb_matrix_bram_reader.sv
// tb_matrix_bram_reader: 2x3 table walks, 5x5 random backpressure
// against a reference sequence, mid-walk reset, and 1x1 case.
module tb_matrix_bram_reader;
    import matrix_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    matrix_bram_reader_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32),
        .ROW_WIDTH(1), .COL_WIDTH(2)) ifa ();
    matrix_bram_reader_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32),
        .ROW_WIDTH(3), .COL_WIDTH(3)) ifb ();
    matrix_bram_reader_if #(.ADDR_WIDTH(1), .DATA_WIDTH(32),
        .ROW_WIDTH(1), .COL_WIDTH(1)) ifc ();

    matrix_bram_reader #(.ROWS(2), .COLS(3), .ADDR_WIDTH(3),
        .DATA_WIDTH(32)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    matrix_bram_reader #(.ROWS(5), .COLS(5), .ADDR_WIDTH(5),
        .DATA_WIDTH(32)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    matrix_bram_reader #(.ROWS(1), .COLS(1), .ADDR_WIDTH(1),
        .DATA_WIDTH(32)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    matrix_elem_t mem_a [6];
    matrix_elem_t mem_b [25];
    matrix_elem_t mem_c [2];

    // registered-read BRAM models
    always @(posedge clk) begin
        ifa.bram_dout <= mem_a[ifa.bram_addr];
        ifb.bram_dout <= mem_b[ifb.bram_addr];
        ifc.bram_dout <= mem_c[ifc.bram_addr];
    end

    typedef struct {
        int data;
        int row;
        int col;
        bit last;
    } vec_t;

    vec_t va [12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic l, input integer r,
                                       input integer c, input integer d);
        return {15'b0, l, r[7:0], c[7:0], d[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic walk_a(input bit tr, input int vbase,
                          input int pulse_at, input bit restart);
        int k, fv, dc, nd, lastc;
        vec_t e;
        k = 0; fv = -1; dc = -1; nd = 0; lastc = -1;
        ifa.transpose = tr;
        ifa.out_ready = 1'b1;
        ifa.start     = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 1) begin
                chk("a_busy_c1", ifa.busy, 1);
                chk("a_addr_c1", ifa.bram_addr, 0);
            end
            if (t == 2) chk("a_addr_c2", ifa.bram_addr, tr ? 3 : 1);
            if (restart && dc >= 0 && t == dc + 1)
                chk("a_restart_busy", ifa.busy, 1);
            if (ifa.out_valid && fv < 0) fv = t;
            if (ifa.done) begin
                nd++;
                if (dc < 0) dc = t;
                chk("a_busy_at_done", ifa.busy, 0);
            end
            ifa.start = (t == pulse_at) || (restart && ifa.done && nd == 1);
            if (ifa.out_valid) begin
                e = va[vbase + (k % 6)];
                chk("a_elem",
                    pk(ifa.out_last, ifa.out_row, ifa.out_col, ifa.out_data),
                    pk(e.last, e.row, e.col, e.data));
                if (ifa.out_last && lastc < 0) lastc = t;
                k++;
            end
        end
        chk("a_first_valid", fv, 3);
        chk("a_last_cycle", lastc, 8);
        chk("a_done_cycle", dc, 9);
        chk("a_count", k, restart ? 12 : 6);
        chk("a_ndone", nd, restart ? 2 : 1);
    endtask

    task automatic walk_b(input bit tr, input bit do_reset);
        logic [63:0] q[$];
        logic [63:0] cur, pv, exp;
        logic [4:0]  prev_addr;
        int issued, hs, r, c;
        bit stall, done_seen;
        for (int i = 0; i < 25; i++) begin
            r = tr ? i % 5 : i / 5;
            c = tr ? i / 5 : i % 5;
            q.push_back(pk(i == 24, r, c, mem_b[r * 5 + c]));
        end
        issued = 0; hs = 0; stall = 0; done_seen = 0; pv = '0;
        prev_addr = ifb.bram_addr;
        ifb.transpose = tr;
        ifb.start     = 1'b1;
        ifb.out_ready = ($urandom_range(0, 9) < 3);
        for (int t = 1; t <= 800; t++) begin
            tick();
            ifb.start = 1'b0;
            if (ifb.bram_addr !== prev_addr) issued++;
            prev_addr = ifb.bram_addr;
            chk("b_credit", (issued - hs) > 4, 0);
            cur = pk(ifb.out_last, ifb.out_row, ifb.out_col, ifb.out_data);
            if (stall) begin
                chk("b_stall_valid", ifb.out_valid, 1);
                chk("b_stall_hold", cur, pv);
            end
            ifb.out_ready = ($urandom_range(0, 9) < 3);
            if (ifb.out_valid && ifb.out_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : '1;
                chk("b_elem", cur, exp);
                hs++;
                if (do_reset && hs == 7) begin
                    rst_n = 1'b0;
                    tick();
                    rst_n = 1'b1;
                    chk("b_reset_outputs",
                        {ifb.busy, ifb.done, ifb.out_valid, ifb.out_last,
                         ifb.bram_addr, ifb.out_data, ifb.out_row,
                         ifb.out_col}, 0);
                    for (int j = 0; j < 10; j++) begin
                        tick();
                        chk("b_no_valid_after_reset", ifb.out_valid, 0);
                    end
                    return;
                end
            end
            stall = ifb.out_valid && !ifb.out_ready;
            pv = cur;
            if (ifb.done) begin
                done_seen = 1;
                break;
            end
        end
        chk("b_done_seen", done_seen, 1);
        chk("b_handshakes", hs, 25);
        chk("b_leftover", q.size(), 0);
    endtask

    task automatic walk_c();
        int fv, dc;
        fv = -1; dc = -1;
        ifc.transpose = 1'b0;
        ifc.out_ready = 1'b1;
        ifc.start     = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            ifc.start = 1'b0;
            if (t == 1) chk("c_busy_c1", ifc.busy, 1);
            if (ifc.out_valid) begin
                if (fv < 0) fv = t;
                chk("c_elem",
                    pk(ifc.out_last, ifc.out_row, ifc.out_col, ifc.out_data),
                    pk(1'b1, 0, 0, 32'hDEADBEEF));
            end
            if (ifc.done && dc < 0) dc = t;
        end
        chk("c_first_valid", fv, 3);
        chk("c_done_cycle", dc, 4);
    endtask

    initial begin
        va[0]  = '{10, 0, 0, 0};
        va[1]  = '{11, 0, 1, 0};
        va[2]  = '{12, 0, 2, 0};
        va[3]  = '{13, 1, 0, 0};
        va[4]  = '{14, 1, 1, 0};
        va[5]  = '{15, 1, 2, 1};
        va[6]  = '{10, 0, 0, 0};
        va[7]  = '{13, 1, 0, 0};
        va[8]  = '{11, 0, 1, 0};
        va[9]  = '{14, 1, 1, 0};
        va[10] = '{12, 0, 2, 0};
        va[11] = '{15, 1, 2, 1};
        for (int i = 0; i < 6; i++) mem_a[i] = 32'(10 + i);
        for (int i = 0; i < 25; i++) mem_b[i] = $urandom;
        mem_c[0] = 32'hDEADBEEF;
        mem_c[1] = 32'h0;

        rst_n = 1'b0;
        ifa.start = 0; ifa.transpose = 0; ifa.out_ready = 0;
        ifb.start = 0; ifb.transpose = 0; ifb.out_ready = 0;
        ifc.start = 0; ifc.transpose = 0; ifc.out_ready = 0;
        tick();
        tick();
        chk("rst_a", {ifa.busy, ifa.done, ifa.out_valid, ifa.out_last,
            ifa.bram_addr, ifa.out_data, ifa.out_row, ifa.out_col}, 0);
        chk("rst_b", {ifb.busy, ifb.done, ifb.out_valid, ifb.out_last,
            ifb.bram_addr, ifb.out_data, ifb.out_row, ifb.out_col}, 0);
        chk("rst_c", {ifc.busy, ifc.done, ifc.out_valid, ifc.out_last,
            ifc.bram_addr, ifc.out_data, ifc.out_row, ifc.out_col}, 0);
        rst_n = 1'b1;
        tick();

        walk_a(1'b0, 0, -1, 1'b0);
        walk_a(1'b1, 6, -1, 1'b0);
        walk_a(1'b0, 0, 5, 1'b1);

        walk_b(1'b0, 1'b0);
        walk_b(1'b1, 1'b0);
        walk_b(1'b0, 1'b1);
        walk_b(1'b0, 1'b0);

        walk_c();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/matrix_bram_reader.md
# matrix_bram_reader

Read-side sequencer for a `matrix_bram` instance. On a start pulse it walks all ROWS×COLS addresses, in row-major or column-major (transpose) order. It absorbs the BRAM's one-cycle registered read latency and presents the elements as a valid/ready stream tagged with source row/column and a last flag. It sits between the matrix store and downstream compute or UART-output stages.

## Interface
Parameters:
- `ROWS`, 5, matrix row count (≥1)
- `COLS`, 5, matrix column count (≥1)
- `ADDR_WIDTH`, `$clog2(ROWS*COLS)`, BRAM address width; must be ≥1
- `DATA_WIDTH`, 32, element width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  begin a full-matrix read; sampled only while `busy`=0
- `transpose`  in  1  0 = row-major, 1 = column-major; sampled with `start`
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse after the final output handshake
- `bram_addr`  out  ADDR_WIDTH  registered address to BRAM `addr`
- `bram_dout`  in  DATA_WIDTH  BRAM `dout`; valid the cycle after the address is presented
- `out_valid`  out  1  stream element valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  DATA_WIDTH  element value
- `out_row`  out  $clog2(ROWS) (min 1)  source row of element
- `out_col`  out  $clog2(COLS) (min 1)  source column of element
- `out_last`  out  1  high with the final element (index ROWS*COLS-1 in walk order)

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start` with `busy`=0.
  - RUN→DRAIN once the last address is issued.
  - DRAIN→IDLE on the handshake of the `out_last` element, which sets `done`.
- `start` while busy: ignored, no effect on the walk in progress. `start` in the `done` cycle is accepted because `busy`=0.
- Address generation uses counters (r, c) and an incremental address, with no multiplier.
  - Row-major: addr+1; c wraps at COLS-1 and r increments.
  - Column-major: addr+COLS; r wraps at ROWS-1, then c increments and addr resets to c+1.
- Issue sequence: each issued address pushes its (r, c, last) tag into a tag pipe aligned with BRAM latency. The returning `bram_dout` plus its tag are written into a 4-entry output FIFO.
- Credit rule: issue a new address only when (FIFO occupancy + reads in flight − pop this cycle) < 4. The FIFO never overflows and no read is lost.
- Stream rules:
  - `out_data`/`out_row`/`out_col`/`out_last` are stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops without a handshake.
  - `out_valid` is independent of `out_ready`.
- The block never drives BRAM `wr_en`. The write-port mux lives outside.
- Reset at any time, including mid-walk: state IDLE, FIFO and tag pipe flushed, counters cleared. No stale element is emitted after reset.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `bram_addr`=0, `out_data`/`out_row`/`out_col`=0.
- `start` high in cycle 0 gives:
  - `busy`=1 and `bram_addr`=first address in cycle 1
  - BRAM word in cycle 2
  - first `out_valid` in cycle 3
- With `out_ready` held 1: one element per cycle, `out_last` in cycle 2+ROWS*COLS, `done` in cycle 3+ROWS*COLS with `busy`=0 in the same cycle.
- Backpressure: address issue stalls within one cycle of FIFO credit exhaustion. Throughput recovers to 1/cycle once `out_ready` returns to 1.
- 1×1 matrix: single element carries `out_last`=1. RUN lasts one cycle.

## Structure
- Shared package `matrix_pkg`:
  - element type `matrix_elem_t` (DATA_WIDTH-wide logic)
  - state enum `rd_state_t` {IDLE, RUN, DRAIN}
  - constant `READER_FIFO_DEPTH` = 4
- One sub-module: `matrix_stream_fifo`, a parameterised synchronous FIFO (depth, width) with push/pop, full/empty and occupancy count. It holds `{last, row, col, data}`.
- Top level holds the FSM, address/index counters, tag pipe and credit logic.

## Test plan
- ROWS=2, COLS=3, BRAM preloaded 10..15, `transpose`=0, `out_ready`=1:
  - stream 10,11,12,13,14,15 with (r,c) (0,0)…(1,2)
  - first valid in cycle 3, `out_last` on 15, `done` in cycle 9.
- Same preload, `transpose`=1:
  - stream 10,13,11,14,12,15 with (r,c) (0,0),(1,0),(0,1),(1,1),(0,2),(1,2).
- 5×5, `out_ready` random 30% duty:
  - 25 elements in order with no loss or duplication
  - outputs stable during every stall
  - `bram_addr` never issued while 4 credits are held.
- `start` pulsed again in cycle 5 of a walk:
  - ignored; exactly one `done`.
  - `start` in the `done` cycle launches a second full walk.
- `rst_n`=0 for one cycle mid-walk (after 7 handshakes):
  - next cycle all outputs at reset values
  - no `out_valid` until a new `start`, whose walk begins at element 0.
- ROWS=1, COLS=1, value 0xDEADBEEF:
  - single element, `out_last`=1, (r,c)=(0,0), `done` one cycle later.
